// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state type and default geometry for the data-memory responder
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction
    localparam int DEF_XLEN = 64;
    localparam int DEF_DEPTH = 1024;
    localparam int DEF_IDX_W = idx_w(DEF_DEPTH);
    localparam logic [63:0] DEF_BASE_ADDR = 64'h8000_0000;
endpackage

// File: rtl/dmem_sram_bank.sv
// dmem_sram_bank: single-port synchronous RAM with 8 byte-lane write strobes and registered read
module dmem_sram_bank
    import dmem_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int DEPTH_WORDS = DEF_DEPTH,
    parameter int IW = idx_w(DEPTH_WORDS)
) (
    input  logic            clk,
    input  logic            en,
    input  logic            we,
    input  logic [7:0]      wmask,
    input  logic [IW-1:0]   addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata
);
    localparam int LW = XLEN / 8;
    logic [XLEN-1:0] mem [DEPTH_WORDS];
    always_ff @(posedge clk) begin
        if (en && we)
            for (int i = 0; i < 8; i++)
                if (wmask[i]) mem[addr][i*LW +: LW] <= wdata[i*LW +: LW];
        if (en && !we) rdata <= mem[addr];
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: one-at-a-time load/store responder with fixed latency and window check
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int DEPTH_WORDS = DEF_DEPTH,
    parameter int LATENCY = 2,
    parameter logic [XLEN-1:0] BASE_ADDR = XLEN'(DEF_BASE_ADDR)
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    input  logic            req_we,
    input  logic [7:0]      req_wmask,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err
);
    localparam int IW = idx_w(DEPTH_WORDS);
    localparam logic [XLEN-1:0] SPAN = XLEN'(DEPTH_WORDS) << 3;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
    state_t state, next_state;
    logic [3:0] cnt;
    logic we_q, err_q, in_range, accept;
    logic [XLEN-1:0] off, sram_rdata;
    // wrapped subtraction makes addresses below the base look huge, so one compare covers both ends
    assign off = req_addr - BASE_ADDR;
    assign in_range = off < SPAN;
    assign accept = state == IDLE && req_ready && req_valid;
    dmem_sram_bank #(.XLEN(XLEN), .DEPTH_WORDS(DEPTH_WORDS), .IW(IW)) u_bank (
        .clk(sys_clk),
        .en(accept && in_range),
        .we(req_we),
        .wmask(req_wmask),
        .addr(off[IW+2:3]),
        .wdata(req_wdata),
        .rdata(sram_rdata)
    );
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state <= IDLE;
            req_ready <= 1'b0;
            cnt <= '0;
            we_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= next_state;
            req_ready <= next_state == IDLE;
            cnt <= accept ? CNT_INIT : state == WAIT ? cnt - 4'd1 : cnt;
            if (accept) begin
                we_q <= req_we;
                err_q <= !in_range;
            end
        end
    end
    always_comb
        next_state = state == IDLE ? (accept ? (LATENCY > 1 ? WAIT : RESP) : IDLE)
                   : state == WAIT ? (cnt == 4'd1 ? RESP : WAIT)
                   : (resp_ready ? IDLE : RESP);
    // the bank's read register only reloads on accept, so data holds through backpressure
    always_comb begin
        resp_valid = state == RESP;
        resp_err = resp_valid && err_q;
        resp_rdata = resp_valid && !we_q && !err_q ? sram_rdata : '0;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder with a byte-level memory model
module tb_dmem_responder;
    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam int LAT = 2;
    typedef struct {
        logic [63:0] d;
        logic        e;
    } exp_t;
    logic sys_clk = 1'b0, sys_rst = 1'b0, req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
    logic req_ready, resp_valid, resp_err;
    logic [63:0] req_addr = '0, req_wdata = '0, resp_rdata;
    logic [7:0] req_wmask = '0;
    exp_t sb[$];
    logic [63:0] mdl [longint];
    int compared = 0, mismatched = 0;

    always #5 sys_clk = ~sys_clk;

    dmem_responder #(.LATENCY(LAT)) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr(req_addr),
        .req_we(req_we),
        .req_wmask(req_wmask),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err(resp_err)
    );

    function automatic exp_t model(input logic [63:0] a, input logic we, input logic [7:0] m,
                                   input logic [63:0] wd);
        exp_t x;
        logic [63:0] w;
        longint idx;
        idx = longint'((a - BASE) >> 3);
        x.e = !(a >= BASE && a < BASE + 64'h2000);
        x.d = '0;
        if (!x.e) begin
            w = mdl.exists(idx) ? mdl[idx] : '0;
            if (we) begin
                for (int i = 0; i < 8; i++) if (m[i]) w[i*8 +: 8] = wd[i*8 +: 8];
                mdl[idx] = w;
            end else x.d = w;
        end
        return x;
    endfunction

    task automatic send(input logic [63:0] a, input logic we, input logic [7:0] m, input logic [63:0] wd);
        int w = 0;
        req_addr = a;
        req_we = we;
        req_wmask = m;
        req_wdata = wd;
        req_valid = 1'b1;
        while (!req_ready && w < 50) begin
            @(negedge sys_clk);
            w++;
        end
        compared++;
        if (req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL accept_timeout addr=%h req_ready=%b required 1", a, req_ready);
        end
        @(posedge sys_clk);
        sb.push_back(model(a, we, m, wd));
        #1 req_valid = 1'b0;
    endtask

    task automatic recv(output logic [63:0] d, output logic e, output int lat);
        lat = 0;
        do begin
            @(negedge sys_clk);
            lat++;
        end while (!resp_valid && lat < 50);
        d = resp_rdata;
        e = resp_err;
        resp_ready = 1'b1;
        @(posedge sys_clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst = 1'b0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        compared += 4;
        if (req_ready !== 1'b0) begin mismatched++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
        if (resp_valid !== 1'b0) begin mismatched++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
        if (resp_rdata !== 64'h0) begin mismatched++; $display("FAIL rst_resp_rdata got=%h exp=0", resp_rdata); end
        if (resp_err !== 1'b0) begin mismatched++; $display("FAIL rst_resp_err got=%b exp=0", resp_err); end
        sys_rst = 1'b1;
        #1;
        compared++;
        if (req_ready !== 1'b0) begin mismatched++; $display("FAIL ready_before_edge got=%b exp=0", req_ready); end
        @(posedge sys_clk);
        #1;
        compared += 2;
        if (req_ready !== 1'b1) begin mismatched++; $display("FAIL ready_after_edge got=%b exp=1", req_ready); end
        if (resp_valid !== 1'b0) begin mismatched++; $display("FAIL idle_resp_valid got=%b exp=0", resp_valid); end
        repeat (3) begin
            @(negedge sys_clk);
            compared++;
            if (resp_valid !== 1'b0) begin mismatched++; $display("FAIL idle_quiet got=%b exp=0", resp_valid); end
        end
    endtask

    task automatic test_store_load();
        logic [63:0] d;
        logic e;
        int lat;
        exp_t x;
        send(BASE + 64'h10, 1'b1, 8'hFF, 64'h1122_3344_5566_7788);
        recv(d, e, lat);
        x = sb.pop_front();
        compared += 3;
        if (lat != LAT) begin mismatched++; $display("FAIL store_latency got=%0d exp=%0d", lat, LAT); end
        if (d !== 64'h0 || d !== x.d) begin mismatched++; $display("FAIL store_rdata got=%h exp=0", d); end
        if (e !== 1'b0) begin mismatched++; $display("FAIL store_err got=%b exp=0", e); end
        send(BASE + 64'h10, 1'b0, 8'h00, 64'h0);
        recv(d, e, lat);
        x = sb.pop_front();
        compared += 3;
        if (lat != LAT) begin mismatched++; $display("FAIL load_latency got=%0d exp=%0d", lat, LAT); end
        if (d !== 64'h1122_3344_5566_7788 || d !== x.d)
            begin mismatched++; $display("FAIL load_rdata got=%h exp=%h", d, x.d); end
        if (e !== 1'b0) begin mismatched++; $display("FAIL load_err got=%b exp=0", e); end
    endtask

    task automatic test_byte_strobe();
        logic [63:0] d;
        logic e;
        int lat;
        exp_t x;
        send(BASE + 64'h20, 1'b1, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        recv(d, e, lat);
        x = sb.pop_front();
        send(BASE + 64'h20, 1'b1, 8'h0C, 64'h0000_0000_AABB_0000);
        recv(d, e, lat);
        x = sb.pop_front();
        compared++;
        if (e !== 1'b0 || d !== 64'h0) begin mismatched++; $display("FAIL strobe_store got=%h/%b exp=0/0", d, e); end
        send(BASE + 64'h20, 1'b0, 8'h00, 64'h0);
        recv(d, e, lat);
        x = sb.pop_front();
        compared += 2;
        if (d !== 64'hFFFF_FFFF_AABB_FFFF || d !== x.d)
            begin mismatched++; $display("FAIL strobe_load got=%h exp=%h", d, x.d); end
        if (lat != LAT) begin mismatched++; $display("FAIL strobe_latency got=%0d exp=%0d", lat, LAT); end
    endtask

    task automatic test_boundaries();
        logic [63:0] d;
        logic e;
        int lat;
        exp_t x;
        logic [63:0] ta [8];
        logic        tw [8];
        logic [7:0]  tm [8];
        logic [63:0] td [8];
        logic        te [8];
        ta = '{BASE, 64'h7FFF_FFF8, 64'h8000_2000, 64'h8000_1FF8, 64'h8000_1FF8, 64'h8000_1FFF,
               64'h8000_2000, BASE};
        tw = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tm = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00};
        td = '{64'hA5A5_A5A5_A5A5_A5A5, 64'h0, 64'h0, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h0, 64'h5555_5555_5555_5555, 64'h0};
        te = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            send(ta[i], tw[i], tm[i], td[i]);
            recv(d, e, lat);
            x = sb.pop_front();
            compared += 3;
            if (e !== te[i] || e !== x.e)
                begin mismatched++; $display("FAIL bound_err[%0d] addr=%h got=%b exp=%b", i, ta[i], e, te[i]); end
            if (d !== x.d)
                begin mismatched++; $display("FAIL bound_rdata[%0d] addr=%h got=%h exp=%h", i, ta[i], d, x.d); end
            if (lat != LAT)
                begin mismatched++; $display("FAIL bound_latency[%0d] got=%0d exp=%0d", i, lat, LAT); end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] d;
        logic e;
        int lat;
        int w = 0;
        exp_t x, y;
        send(BASE + 64'h10, 1'b0, 8'h00, 64'h0);
        x = sb.pop_front();
        req_addr = 64'h8000_1FF8;
        req_we = 1'b0;
        req_wmask = 8'h00;
        req_wdata = 64'h0;
        req_valid = 1'b1;
        while (!resp_valid && w < 50) begin
            @(negedge sys_clk);
            w++;
        end
        compared++;
        if (resp_valid !== 1'b1) begin mismatched++; $display("FAIL bp_valid_timeout got=%b exp=1", resp_valid); end
        repeat (10) begin
            compared++;
            if (resp_valid !== 1'b1 || resp_rdata !== x.d || resp_err !== x.e || req_ready !== 1'b0) begin
                mismatched++;
                $display("FAIL bp_hold valid=%b rdata=%h err=%b ready=%b exp 1/%h/%b/0",
                         resp_valid, resp_rdata, resp_err, req_ready, x.d, x.e);
            end
            @(negedge sys_clk);
        end
        resp_ready = 1'b1;
        @(posedge sys_clk);
        #1 resp_ready = 1'b0;
        compared += 2;
        if (resp_valid !== 1'b0) begin mismatched++; $display("FAIL bp_release_valid got=%b exp=0", resp_valid); end
        if (req_ready !== 1'b1) begin mismatched++; $display("FAIL bp_release_ready got=%b exp=1", req_ready); end
        @(posedge sys_clk);
        sb.push_back(model(req_addr, req_we, req_wmask, req_wdata));
        #1 req_valid = 1'b0;
        compared++;
        if (req_ready !== 1'b0) begin mismatched++; $display("FAIL bp_second_accept ready got=%b exp=0", req_ready); end
        recv(d, e, lat);
        y = sb.pop_front();
        compared += 2;
        if (d !== 64'h0123_4567_89AB_CDEF || d !== y.d)
            begin mismatched++; $display("FAIL bp_second_rdata got=%h exp=%h", d, y.d); end
        if (lat != LAT) begin mismatched++; $display("FAIL bp_second_latency got=%0d exp=%0d", lat, LAT); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] d;
        logic e;
        int lat;
        exp_t x;
        send(BASE + 64'h40, 1'b1, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D);
        sys_rst = 1'b0;
        #1;
        x = sb.pop_front();
        compared += 2;
        if (resp_valid !== 1'b0) begin mismatched++; $display("FAIL midrst_valid got=%b exp=0", resp_valid); end
        if (req_ready !== 1'b0) begin mismatched++; $display("FAIL midrst_ready got=%b exp=0", req_ready); end
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        repeat (3) begin
            @(negedge sys_clk);
            compared++;
            if (resp_valid !== 1'b0) begin mismatched++; $display("FAIL midrst_dropped got=%b exp=0", resp_valid); end
        end
        send(BASE + 64'h40, 1'b0, 8'h00, 64'h0);
        recv(d, e, lat);
        x = sb.pop_front();
        compared += 2;
        if (d !== 64'hDEAD_BEEF_CAFE_F00D || d !== x.d)
            begin mismatched++; $display("FAIL midrst_load got=%h exp=%h", d, x.d); end
        if (e !== 1'b0) begin mismatched++; $display("FAIL midrst_err got=%b exp=0", e); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_store_load();
        test_byte_strobe();
        test_boundaries();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
